cpu_datapath: RTL and testbench
===============================

# cpu_datapath

32-bit bus-based CPU datapath for the phase-3 processor: sixteen general registers with select-and-encode, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, an opcode-driven ALU, 512×32 RAM, CON flip-flop and I/O port registers, all joined by one multiplexed 32-bit bus. An external control unit (or testbench FSM) sequences it purely through one-hot control inputs; it contains no state machine of its own.

## Interface
- No parameters.
- clock  in  1  all registers and RAM write sample on rising edge
- clear  in  1  asynchronous, active-high reset
- PCout, MDRout, MARout, IRout, RZoutHi, RZoutLo, RYout, RCout, HIout, LOout, InPortout  in  1 each  bus-source selects
- Rout, BAout  in  1 each  drive register picked by Gra/Grb/Grc (BAout: R0 reads as 0)
- PCin, IRin, MARin, MDRin, RYin, RZinHi, RZinLo, HIin, LOin, CONin, OutPortIn, InPortIn  in  1 each  load enables
- Rin  in  1  write bus into register picked by Gra/Grb/Grc
- R1in, R2in, R3in, R6in  in  1 each  direct bus load of R1/R2/R3/R6
- Gra, Grb, Grc  in  1 each  register-field select
- IncPC  in  1  PC <= PC+1
- MDRread  in  1  MDR input mux selects RAM data instead of bus
- RAMwrite  in  1  RAM[MAR[8:0]] <= MDR
- InPortData  in  32  external input-port data
- BusMuxOut  out  32  current bus value
- OutPortData  out  32  output-port register
- CON  out  1  branch-condition flip-flop

## Operation
- Bus: fixed-priority mux in port order listed above (PCout highest … InPortout lowest, then Rout/BAout); only inputs equal to 1 count as asserted; no source -> bus = 0.
- IR fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0] sign-extended to 32 bits, C2=IR[20:19].
- Select-and-encode: Gra/Grb/Grc choose Ra/Rb/Rc (more than one set: OR of fields). Rin loads selected register; Rout drives it; BAout drives it except R0 drives 0. Rx-in direct enables and Rin may combine.
- RCout drives sign-extended C.
- MDR: MDRin loads RAM[MAR[8:0]] (async read) when MDRread=1, else bus.
- RAM: 512×32, written at rising edge when RAMwrite; contents unaffected by clear, zero at time 0.
- PC: PCin loads bus; IncPC increments (wraps at 2^32); both -> PCin wins.
- ALU: A=Y, B=bus, op from IR. ld/ldi/st/addi/add(00000/00001/00010/01011/00011) A+B; sub 00100 A-B; and/andi 00101/01100; or/ori 00110/01101; shr 00111 logical, shl 01000, ror 01001, rol 01010 (amount B[4:0]); mul 01110 signed 64-bit; neg 10000 -B; not 10001 ~B; others pass B. Non-mul results sign-extended into Z high word. RZinLo/RZinHi load respective halves independently.
- CON: on CONin, C2 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
- InPortIn captures InPortData; OutPortIn captures bus.

## Timing
- All loads single-cycle: value on bus during cycle with enable captured at next rising edge; visible on bus next cycle.
- ALU, bus mux, RAM read purely combinational; ld effective address in 3 cycles (Y, Z, MAR).
- clear: every register, PC, IR, MAR, MDR, Y, Z, HI, LO, CON, ports -> 0 immediately, regardless of clock; BusMuxOut then 0 unless a driver selected; operations in flight are lost.
- Load and drive same register in one cycle: bus shows old value, register gets bus.

## Configuration
- DATAPATH_MUL_EN defined: mul opcode performs signed 32×32->64 multiply. Undefined: mul yields Z=0, no multiplier synthesized.

## Test plan
- clear mid-run with R3=5, PC=7 -> all read 0 same cycle.
- RAM[0]=0x1180_0004 (st R3, 4(R0)): PCout/MARin, MDRread/MDRin, MDRout/IRin -> IR=0x11800004.
- st sequence, R3=0x55: Grb/BAout/RYin -> Y=0; RCout/RZinLo -> Z=4; RZoutLo/MARin -> MAR=4; Gra/Rout/MDRin -> MDR=0x55; MDRout/RAMwrite -> RAM[4]=0x55.
- ld R1,4(R2) with R2=2, RAM[6]=0xABCD -> R1=0xABCD after 5 cycles.
- mul with Y=-3, bus=7 (DATAPATH_MUL_EN) -> Z=0xFFFFFFFF_FFFFFFEB.
- CONin with C2=00, bus=0 -> CON=1; bus=1 -> CON=0.

Source files
------------

// File: rtl/cpu_datapath_if.sv
// Control/data bundle between an external control unit and the CPU datapath.
// Master drives the one-hot control strobes and input-port data; slave returns bus, out-port and CON.
// Pure wiring bundle, no storage and no flow control.
interface cpu_datapath_if;
  // bus-source selects, in priority order
  logic        PCout, MDRout, MARout, IRout, RZoutHi, RZoutLo, RYout, RCout;
  logic        HIout, LOout, InPortout, Rout, BAout;
  // load enables
  logic        PCin, IRin, MARin, MDRin, RYin, RZinHi, RZinLo, HIin, LOin;
  logic        CONin, OutPortIn, InPortIn, Rin;
  logic        R1in, R2in, R3in, R6in;
  // register-field select and misc controls
  logic        Gra, Grb, Grc, IncPC, MDRread, RAMwrite;
  // data
  logic [31:0] InPortData;
  logic [31:0] BusMuxOut;
  logic [31:0] OutPortData;
  logic        CON;

  modport master (
    output PCout, MDRout, MARout, IRout, RZoutHi, RZoutLo, RYout, RCout,
    output HIout, LOout, InPortout, Rout, BAout,
    output PCin, IRin, MARin, MDRin, RYin, RZinHi, RZinLo, HIin, LOin,
    output CONin, OutPortIn, InPortIn, Rin, R1in, R2in, R3in, R6in,
    output Gra, Grb, Grc, IncPC, MDRread, RAMwrite, InPortData,
    input  BusMuxOut, OutPortData, CON
  );

  modport slave (
    input  PCout, MDRout, MARout, IRout, RZoutHi, RZoutLo, RYout, RCout,
    input  HIout, LOout, InPortout, Rout, BAout,
    input  PCin, IRin, MARin, MDRin, RYin, RZinHi, RZinLo, HIin, LOin,
    input  CONin, OutPortIn, InPortIn, Rin, R1in, R2in, R3in, R6in,
    input  Gra, Grb, Grc, IncPC, MDRread, RAMwrite, InPortData,
    output BusMuxOut, OutPortData, CON
  );
endinterface

// File: rtl/cpu_datapath.sv
// Bus-based 32-bit CPU datapath (GPRs, PC, IR, MAR, MDR, Y, Z, HI/LO, ALU, 512x32 RAM, CON, I/O ports).
// Bus/ALU/RAM read combinational; every register load lands on the next rising clock edge.
// No backpressure: the external control unit owns all sequencing. DATAPATH_MUL_EN enables the signed multiplier.
module cpu_datapath (
  input  logic           clock,
  input  logic           clear,
  cpu_datapath_if.slave  dp
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  // architectural state
  logic [31:0] r_gpr [16];
  logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_inport, r_outport;
  logic [63:0] r_z;
  logic        r_con;
  logic [31:0] r_ram [512];

  // decoded IR fields
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc, w_sel;
  logic [31:0] w_c;
  logic [1:0]  w_c2;

  logic [31:0] w_sel_val, w_ba_val, w_ram_rd, w_bus;
  logic [31:0] w_alu_lo;
  logic [63:0] w_alu, w_mul, w_dbl, w_ror_dbl, w_rol_dbl;
  logic [4:0]  w_amt;

  assign w_op  = r_ir[31:27];
  assign w_ra  = r_ir[26:23];
  assign w_rb  = r_ir[22:19];
  assign w_rc  = r_ir[18:15];
  assign w_c   = {{13{r_ir[18]}}, r_ir[18:0]};
  assign w_c2  = r_ir[20:19];

  // several field selects at once simply OR their register numbers together
  assign w_sel = ({4{dp.Gra}} & w_ra) | ({4{dp.Grb}} & w_rb) | ({4{dp.Grc}} & w_rc);
  assign w_sel_val = r_gpr[w_sel];
  assign w_ba_val  = (w_sel == 4'd0) ? 32'd0 : w_sel_val;
  assign w_ram_rd  = r_ram[r_mar[8:0]];

  // fixed-priority bus source mux; nothing selected leaves the bus at zero
  always_comb begin
    w_bus = '0;
    if      (dp.PCout     == 1'b1) w_bus = r_pc;
    else if (dp.MDRout    == 1'b1) w_bus = r_mdr;
    else if (dp.MARout    == 1'b1) w_bus = r_mar;
    else if (dp.IRout     == 1'b1) w_bus = r_ir;
    else if (dp.RZoutHi   == 1'b1) w_bus = r_z[63:32];
    else if (dp.RZoutLo   == 1'b1) w_bus = r_z[31:0];
    else if (dp.RYout     == 1'b1) w_bus = r_y;
    else if (dp.RCout     == 1'b1) w_bus = w_c;
    else if (dp.HIout     == 1'b1) w_bus = r_hi;
    else if (dp.LOout     == 1'b1) w_bus = r_lo;
    else if (dp.InPortout == 1'b1) w_bus = r_inport;
    else if (dp.Rout      == 1'b1) w_bus = w_sel_val;
    else if (dp.BAout     == 1'b1) w_bus = w_ba_val;
  end

  // rotates use a doubled operand so a zero amount needs no special case
  assign w_amt     = w_bus[4:0];
  assign w_dbl     = {r_y, r_y};
  assign w_ror_dbl = w_dbl >> w_amt;
  assign w_rol_dbl = w_dbl << w_amt;

`ifdef DATAPATH_MUL_EN
  logic [63:0] w_a_sx, w_b_sx;
  assign w_a_sx = {{32{r_y[31]}}, r_y};
  assign w_b_sx = {{32{w_bus[31]}}, w_bus};
  assign w_mul  = w_a_sx * w_b_sx;
`else
  assign w_mul  = '0;
`endif

  // ALU: A is Y, B is the bus, operation taken from the IR opcode
  always_comb begin
    w_alu_lo = w_bus;
    case (w_op)
      OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ADD: w_alu_lo = r_y + w_bus;
      OP_SUB:           w_alu_lo = r_y - w_bus;
      OP_AND, OP_ANDI:  w_alu_lo = r_y & w_bus;
      OP_OR, OP_ORI:    w_alu_lo = r_y | w_bus;
      OP_SHR:           w_alu_lo = r_y >> w_amt;
      OP_SHL:           w_alu_lo = r_y << w_amt;
      OP_ROR:           w_alu_lo = w_ror_dbl[31:0];
      OP_ROL:           w_alu_lo = w_rol_dbl[63:32];
      OP_MUL:           w_alu_lo = w_mul[31:0];
      OP_NEG:           w_alu_lo = 32'd0 - w_bus;
      OP_NOT:           w_alu_lo = ~w_bus;
      default:          w_alu_lo = w_bus;
    endcase
  end

  assign w_alu = (w_op == OP_MUL) ? w_mul : {{32{w_alu_lo[31]}}, w_alu_lo};

  // general registers: field-selected write plus the direct R1/R2/R3/R6 loads
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
    end else begin
      if (dp.Rin)  r_gpr[w_sel] <= w_bus;
      if (dp.R1in) r_gpr[1]     <= w_bus;
      if (dp.R2in) r_gpr[2]     <= w_bus;
      if (dp.R3in) r_gpr[3]     <= w_bus;
      if (dp.R6in) r_gpr[6]     <= w_bus;
    end
  end

  // PC: a bus load overrides the increment
  always_ff @(posedge clock or posedge clear) begin
    if (clear)          r_pc <= '0;
    else if (dp.PCin)   r_pc <= w_bus;
    else if (dp.IncPC)  r_pc <= r_pc + 32'd1;
  end

  // special-purpose registers loaded straight from the bus, MDR optionally from RAM
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_ir      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_y       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_inport  <= '0;
      r_outport <= '0;
    end else begin
      if (dp.IRin)      r_ir      <= w_bus;
      if (dp.MARin)     r_mar     <= w_bus;
      if (dp.MDRin)     r_mdr     <= dp.MDRread ? w_ram_rd : w_bus;
      if (dp.RYin)      r_y       <= w_bus;
      if (dp.HIin)      r_hi      <= w_bus;
      if (dp.LOin)      r_lo      <= w_bus;
      if (dp.InPortIn)  r_inport  <= dp.InPortData;
      if (dp.OutPortIn) r_outport <= w_bus;
    end
  end

  // Z halves load independently from the 64-bit ALU result
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_z <= '0;
    end else begin
      if (dp.RZinLo) r_z[31:0]  <= w_alu[31:0];
      if (dp.RZinHi) r_z[63:32] <= w_alu[63:32];
    end
  end

  // branch condition evaluated on the bus value using the C2 field
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_con <= 1'b0;
    end else if (dp.CONin) begin
      case (w_c2)
        2'b00:   r_con <= (w_bus == 32'd0);
        2'b01:   r_con <= (w_bus != 32'd0);
        2'b10:   r_con <= ~w_bus[31];
        default: r_con <= w_bus[31];
      endcase
    end
  end

  // RAM write port; memory contents survive clear
  always_ff @(posedge clock) begin
    if (dp.RAMwrite) r_ram[r_mar[8:0]] <= r_mdr;
  end

  assign dp.BusMuxOut   = w_bus;
  assign dp.OutPortData = r_outport;
  assign dp.CON         = r_con;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: expected values queued when stimulus is driven,
// popped and compared when the value is observed on the bus or output ports.
module tb_cpu_datapath;
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  cpu_datapath_if dp ();
  cpu_datapath dut (.clock(clock), .clear(clear), .dp(dp));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got, expv;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } alu_vec_t;

`ifdef DATAPATH_MUL_EN
  localparam logic [63:0] MUL_EXP = 64'hFFFF_FFFF_FFFF_FFEB;
`else
  localparam logic [63:0] MUL_EXP = 64'h0;
`endif

  alu_vec_t vecs [18] = '{
    '{5'b00011, 32'd5,          32'd7,          64'h0000_0000_0000_000C},
    '{5'b00000, 32'hFFFF_FFF0,  32'd1,          64'hFFFF_FFFF_FFFF_FFF1},
    '{5'b01011, 32'h7FFF_FFFF,  32'd1,          64'hFFFF_FFFF_8000_0000},
    '{5'b00100, 32'd3,          32'd5,          64'hFFFF_FFFF_FFFF_FFFE},
    '{5'b00101, 32'h0000_F0F0,  32'h0000_FF00,  64'h0000_0000_0000_F000},
    '{5'b01100, 32'hFFFF_FFFF,  32'h8000_000F,  64'hFFFF_FFFF_8000_000F},
    '{5'b00110, 32'h0000_F0F0,  32'h0000_0F00,  64'h0000_0000_0000_FFF0},
    '{5'b01101, 32'd0,          32'h12,         64'h0000_0000_0000_0012},
    '{5'b00111, 32'h8000_0000,  32'd4,          64'h0000_0000_0800_0000},
    '{5'b00111, 32'h8000_0000,  32'd31,         64'h0000_0000_0000_0001},
    '{5'b01000, 32'd1,          32'd31,         64'hFFFF_FFFF_8000_0000},
    '{5'b01001, 32'd1,          32'd1,          64'hFFFF_FFFF_8000_0000},
    '{5'b01010, 32'h8000_0001,  32'd4,          64'h0000_0000_0000_0018},
    '{5'b01001, 32'h1234_5678,  32'h20,         64'h0000_0000_1234_5678},
    '{5'b10000, 32'd0,          32'd1,          64'hFFFF_FFFF_FFFF_FFFF},
    '{5'b10001, 32'd0,          32'h0000_FFFF,  64'hFFFF_FFFF_FFFF_0000},
    '{5'b11111, 32'd9,          32'h1234,       64'h0000_0000_0000_1234},
    '{5'b01110, 32'hFFFF_FFFD,  32'd7,          MUL_EXP}
  };

  string src_names [11] = '{"pc","mdr","mar","ir","zhi","zlo","y","c","hi","lo","inport"};

  task automatic idle();
    dp.PCout = 0; dp.MDRout = 0; dp.MARout = 0; dp.IRout = 0; dp.RZoutHi = 0; dp.RZoutLo = 0;
    dp.RYout = 0; dp.RCout = 0; dp.HIout = 0; dp.LOout = 0; dp.InPortout = 0; dp.Rout = 0; dp.BAout = 0;
    dp.PCin = 0; dp.IRin = 0; dp.MARin = 0; dp.MDRin = 0; dp.RYin = 0; dp.RZinHi = 0; dp.RZinLo = 0;
    dp.HIin = 0; dp.LOin = 0; dp.CONin = 0; dp.OutPortIn = 0; dp.InPortIn = 0; dp.Rin = 0;
    dp.R1in = 0; dp.R2in = 0; dp.R3in = 0; dp.R6in = 0;
    dp.Gra = 0; dp.Grb = 0; dp.Grc = 0; dp.IncPC = 0; dp.MDRread = 0; dp.RAMwrite = 0;
    dp.InPortData = '0;
  endtask

  task automatic step();
    @(posedge clock); #1; idle();
  endtask

  // load v into the input port, then leave InPortout driving it for the caller's load cycle
  task automatic stage(input logic [31:0] v);
    dp.InPortData = v; dp.InPortIn = 1; step();
    dp.InPortout = 1;
  endtask

  task automatic set_src(input int idx);
    case (idx)
      0: dp.PCout = 1;   1: dp.MDRout = 1;  2: dp.MARout = 1;  3: dp.IRout = 1;
      4: dp.RZoutHi = 1; 5: dp.RZoutLo = 1; 6: dp.RYout = 1;   7: dp.RCout = 1;
      8: dp.HIout = 1;   9: dp.LOout = 1;   default: dp.InPortout = 1;
    endcase
  endtask

  task automatic read_src(input int idx, output logic [31:0] v);
    @(negedge clock); set_src(idx); #1; v = dp.BusMuxOut; idle();
  endtask

  task automatic read_gpr(input logic ba, output logic [31:0] v);
    @(negedge clock); dp.Gra = 1; dp.Rout = !ba; dp.BAout = ba; #1; v = dp.BusMuxOut; idle();
  endtask

  task automatic ram_wr(input logic [31:0] addr, input logic [31:0] data);
    stage(addr); dp.MARin = 1; step();
    stage(data); dp.MDRin = 1; step();
    dp.RAMwrite = 1; step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 11; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 11; i++) begin
      read_src(i, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin errors++; $display("FAIL reset_%s: got %h want %h", src_names[i], got, expv); end
    end
    exp_q.push_back(32'd0);
    @(negedge clock); #1; got = dp.BusMuxOut; expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL reset_nosrc_bus: got %h want %h", got, expv); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    expv = exp_q.pop_front(); checks++;
    if (dp.OutPortData !== expv) begin errors++; $display("FAIL reset_outport: got %h want %h", dp.OutPortData, expv); end
    expv = exp_q.pop_front(); checks++;
    if ({31'd0, dp.CON} !== expv) begin errors++; $display("FAIL reset_con: got %b want %h", dp.CON, expv); end
    @(negedge clock); clear = 0;
  endtask

  task automatic test_clear_midrun();
    stage(32'd5); dp.R3in = 1; step();
    stage(32'h0180_0000); dp.IRin = 1; step();
    stage(32'd7); dp.PCin = 1; step();
    exp_q.push_back(32'd7); exp_q.push_back(32'd5);
    read_src(0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL pre_clear_pc: got %h want %h", got, expv); end
    read_gpr(1'b0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL pre_clear_r3: got %h want %h", got, expv); end
    exp_q.push_back(32'd0);
    @(negedge clock); #2; clear = 1; dp.PCout = 1; #1; got = dp.BusMuxOut; idle();
    expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL clear_pc_same_cycle: got %h want %h", got, expv); end
    exp_q.push_back(32'd0);
    read_src(3, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL clear_ir: got %h want %h", got, expv); end
    @(negedge clock); clear = 0;
    stage(32'h0180_0000); dp.IRin = 1; step();
    exp_q.push_back(32'd0);
    read_gpr(1'b0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL clear_r3: got %h want %h", got, expv); end
  endtask

  task automatic test_pc();
    stage(32'hFFFF_FFFF); dp.PCin = 1; step();
    dp.IncPC = 1; exp_q.push_back(32'd0); step();
    read_src(0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL pc_wrap: got %h want %h", got, expv); end
    dp.IncPC = 1; exp_q.push_back(32'd1); step();
    read_src(0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL pc_inc: got %h want %h", got, expv); end
    stage(32'd9); dp.PCin = 1; dp.IncPC = 1; exp_q.push_back(32'd9); step();
    read_src(0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL pc_load_wins: got %h want %h", got, expv); end
  endtask

  task automatic test_fetch();
    ram_wr(32'd0, 32'h1180_0004);
    stage(32'd0); dp.PCin = 1; step();
    dp.PCout = 1; dp.MARin = 1; step();
    dp.MDRread = 1; dp.MDRin = 1; step();
    dp.MDRout = 1; dp.IRin = 1; exp_q.push_back(32'h1180_0004); step();
    read_src(3, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL fetch_ir: got %h want %h", got, expv); end
  endtask

  task automatic test_store();
    stage(32'h55); dp.R3in = 1; step();
    dp.Grb = 1; dp.BAout = 1; dp.RYin = 1; exp_q.push_back(32'd0); step();
    read_src(6, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_y: got %h want %h", got, expv); end
    exp_q.push_back(32'd4);
    read_src(7, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_c: got %h want %h", got, expv); end
    dp.RCout = 1; dp.RZinLo = 1; exp_q.push_back(32'd4); step();
    read_src(5, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_zlo: got %h want %h", got, expv); end
    dp.RZoutLo = 1; dp.MARin = 1; exp_q.push_back(32'd4); step();
    read_src(2, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_mar: got %h want %h", got, expv); end
    dp.Gra = 1; dp.Rout = 1; dp.MDRin = 1; exp_q.push_back(32'h55); step();
    read_src(1, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_mdr: got %h want %h", got, expv); end
    dp.MDRout = 1; dp.RAMwrite = 1; step();
    stage(32'd0); dp.MDRin = 1; step();
    dp.MDRread = 1; dp.MDRin = 1; exp_q.push_back(32'h55); step();
    read_src(1, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL st_ram4: got %h want %h", got, expv); end
  endtask

  task automatic test_load();
    ram_wr(32'd6, 32'h0000_ABCD);
    stage(32'd2); dp.R2in = 1; step();
    stage(32'h0090_0004); dp.IRin = 1; step();
    dp.Grb = 1; dp.BAout = 1; dp.RYin = 1; step();
    dp.RCout = 1; dp.RZinLo = 1; step();
    dp.RZoutLo = 1; dp.MARin = 1; exp_q.push_back(32'd6); step();
    dp.MDRread = 1; dp.MDRin = 1; step();
    dp.MDRout = 1; dp.Gra = 1; dp.Rin = 1; exp_q.push_back(32'h0000_ABCD); step();
    read_src(2, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL ld_mar: got %h want %h", got, expv); end
    read_gpr(1'b0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL ld_r1: got %h want %h", got, expv); end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 18; i++) begin
      stage(vecs[i].a); dp.RYin = 1; step();
      stage({vecs[i].op, 27'd0}); dp.IRin = 1; step();
      stage(vecs[i].b); dp.RZinLo = 1; dp.RZinHi = 1;
      exp_q.push_back(vecs[i].z[31:0]); exp_q.push_back(vecs[i].z[63:32]);
      step();
      read_src(5, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin errors++; $display("FAIL alu_lo[%0d] op=%b: got %h want %h", i, vecs[i].op, got, expv); end
      read_src(4, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin errors++; $display("FAIL alu_hi[%0d] op=%b: got %h want %h", i, vecs[i].op, got, expv); end
    end
  endtask

  task automatic test_con();
    logic [1:0]  c2v [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [31:0] bv  [8] = '{32'd0, 32'd1, 32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1};
    logic        ev  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      stage({11'd0, c2v[i], 19'd0}); dp.IRin = 1; step();
      stage(bv[i]); dp.CONin = 1; exp_q.push_back({31'd0, ev[i]}); step();
      @(negedge clock); got = {31'd0, dp.CON}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin errors++; $display("FAIL con[%0d] c2=%b: got %0d want %0d", i, c2v[i], got, expv); end
    end
    stage(32'h0004_0000); dp.IRin = 1; step();
    exp_q.push_back(32'hFFFC_0000);
    read_src(7, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL c_sign_ext: got %h want %h", got, expv); end
  endtask

  task automatic test_back_to_back();
    stage(32'd0); dp.IRin = 1; step();
    stage(32'h99); dp.Gra = 1; dp.Rin = 1; step();
    exp_q.push_back(32'h99); exp_q.push_back(32'd0);
    read_gpr(1'b0, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL r0_rout: got %h want %h", got, expv); end
    read_gpr(1'b1, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL r0_baout: got %h want %h", got, expv); end
    stage(32'hAAAA_0000); dp.HIin = 1; step();
    stage(32'h0000_5555); dp.LOin = 1; step();
    stage(32'hCAFE_F00D); dp.OutPortIn = 1; step();
    exp_q.push_back(32'hAAAA_0000); exp_q.push_back(32'h0000_5555); exp_q.push_back(32'hCAFE_F00D);
    read_src(8, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL hi: got %h want %h", got, expv); end
    read_src(9, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL lo: got %h want %h", got, expv); end
    expv = exp_q.pop_front(); checks++;
    if (dp.OutPortData !== expv) begin errors++; $display("FAIL outport: got %h want %h", dp.OutPortData, expv); end
    stage(32'h111); dp.PCin = 1; step();
    stage(32'h222); dp.MDRin = 1; step();
    stage(32'd4); dp.MARin = 1; step();
    exp_q.push_back(32'h111); exp_q.push_back(32'h0000_5555);
    @(negedge clock); dp.PCout = 1; dp.MDRout = 1; dp.LOout = 1; #1; got = dp.BusMuxOut; idle();
    expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL prio_pc: got %h want %h", got, expv); end
    @(negedge clock); dp.LOout = 1; dp.Gra = 1; dp.Rout = 1; #1; got = dp.BusMuxOut; idle();
    expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL prio_lo_over_rout: got %h want %h", got, expv); end
    // drive and reload MDR in one cycle: bus carries the old value, MDR takes RAM[4]
    exp_q.push_back(32'h222); exp_q.push_back(32'h55);
    @(negedge clock); dp.MDRout = 1; dp.MDRread = 1; dp.MDRin = 1; #1; got = dp.BusMuxOut;
    expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL same_cycle_old: got %h want %h", got, expv); end
    step();
    read_src(1, got); expv = exp_q.pop_front(); checks++;
    if (got !== expv) begin errors++; $display("FAIL same_cycle_new: got %h want %h", got, expv); end
  endtask

  initial begin
    clear = 1;
    idle();
    repeat (2) @(posedge clock);
    test_reset();
    test_clear_midrun();
    test_pc();
    test_fetch();
    test_store();
    test_load();
    test_alu();
    test_con();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
